// File: rtl/dgiota_io_pkg.sv
// Shared types and constants for the dgiota serial pad-configuration block.
// Optional readback of the committed config is enabled with DGIOTA_IO_READBACK_EN.
package dgiota_io_pkg;

    localparam int CFG_BITS = 16;

    localparam logic [4:0] BITCNT_FULL = 5'd16;
    localparam logic [4:0] BITCNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int UO_SDO     = 0;
    localparam int UO_ERR     = 1;
    localparam int UO_BUSY    = 2;
    localparam int UO_TOGGLE  = 3;
    localparam int UO_CNT_LSB = 4;

endpackage

// File: rtl/dgiota_sync.sv
// N-flop synchronizer for one asynchronous input bit, with a selectable reset value.
module dgiota_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/dgiota_io_ctrl.sv
// Serial (cs_n/sck/sdi) loader for a 16-bit {oe, out} pad configuration.
// Define DGIOTA_IO_READBACK_EN to shift the previously committed config out on sdo.
module dgiota_io_ctrl
    import dgiota_io_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CFG_BITS    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SHIFT  = ST_SHIFT;
    localparam logic [1:0] COMMIT = ST_COMMIT;

    logic cs_s, sck_s, sdi_s;
    logic cs_p, sck_p;
    logic cs_fall, cs_rise, sck_rise;

    logic [1:0]          state;
    logic [CFG_BITS-1:0] sr;
    logic [4:0]          bit_cnt;
    logic                err;
    logic                toggle;
    logic                busy;
    logic                sdo;

    dgiota_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(cs_s));
    dgiota_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (.clk(clk), .rst_n(rst_n), .d(ui_in[1]), .q(sck_s));
    dgiota_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .rst_n(rst_n), .d(ui_in[2]), .q(sdi_s));

    // Previous synchronized samples; edges compare these against the current ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_p  <= 1'b1;
            sck_p <= 1'b0;
        end else begin
            cs_p  <= cs_s;
            sck_p <= sck_s;
        end
    end

    assign cs_fall  = cs_p & ~cs_s;
    assign cs_rise  = ~cs_p & cs_s;
    assign sck_rise = ~sck_p & sck_s;

    // The config is loaded on the edge that leaves SHIFT, so the pads change one edge
    // after the cs_n rise is seen; COMMIT is the one-cycle busy tail of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
            toggle  <= 1'b0;
            uio_out <= '0;
            uio_oe  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall && ena) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
`ifdef DGIOTA_IO_READBACK_EN
                        sr      <= {uio_oe, uio_out};
`else
                        sr      <= '0;
`endif
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt == BITCNT_FULL) begin
                            state             <= COMMIT;
                            {uio_oe, uio_out} <= sr;
                            err               <= 1'b0;
                            toggle            <= ~toggle;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        sr <= {sr[CFG_BITS-2:0], sdi_s};
                        if (bit_cnt != BITCNT_SAT) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == COMMIT);

`ifdef DGIOTA_IO_READBACK_EN
    assign sdo = sr[CFG_BITS-1];
`else
    assign sdo = 1'b0;
`endif

    always_comb begin
        uo_out                          = '0;
        uo_out[UO_SDO]                  = sdo;
        uo_out[UO_ERR]                  = err;
        uo_out[UO_BUSY]                 = busy;
        uo_out[UO_TOGGLE]               = toggle;
        uo_out[UO_CNT_LSB+3:UO_CNT_LSB] = bit_cnt[3:0];
    end

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_dgiota_io_ctrl.sv
// Directed bench for dgiota_io_ctrl: frames are driven on the serial pins and the
// expected end-of-frame state is queued; a monitor checks it when busy drops.
module tb_dgiota_io_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       cs_n, sck, sdi;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    assign ui_in = {5'b0, sdi, sck, cs_n};

    dgiota_io_ctrl #(.SYNC_STAGES(2), .CFG_BITS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Expected record: {oe[7:0], out[7:0], err, toggle, bit_cnt[3:0]}
    logic [21:0] exp_q[$];
    logic [21:0] exp_rec;
    int          checks = 0;
    int          errors = 0;
    logic        prev_busy = 1'b0;
    logic        busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !uo_out[2]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_end actual=unexpected_frame_end expected=none");
                end else begin
                    exp_rec = exp_q.pop_front();
                    check("frame_oe",     {24'd0, uio_oe},       {24'd0, exp_rec[21:14]});
                    check("frame_out",    {24'd0, uio_out},      {24'd0, exp_rec[13:6]});
                    check("frame_err",    {31'd0, uo_out[1]},    {31'd0, exp_rec[5]});
                    check("frame_toggle", {31'd0, uo_out[3]},    {31'd0, exp_rec[4]});
                    check("frame_cnt",    {28'd0, uo_out[7:4]},  {28'd0, exp_rec[3:0]});
                end
            end
            prev_busy = uo_out[2];
            if (uo_out[2]) busy_seen = 1'b1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // end_mode: 0 = plain cs_n rise, 1 = extra sck rise together with cs_n rise, 2 = leave frame open
    task automatic send_frame(input logic [17:0] data, input int nbits, input int end_mode,
                              input logic [15:0] old_cfg);
        logic exp_sdo;
        cs_n = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < nbits; i++) begin
            sdi = data[nbits-1-i];
            wait_cycles(4);
            if (ena && i < 16) begin
`ifdef DGIOTA_IO_READBACK_EN
                exp_sdo = old_cfg[15-i];
`else
                exp_sdo = 1'b0;
`endif
                @(negedge clk);
                check("sdo_bit", {31'd0, uo_out[0]}, {31'd0, exp_sdo});
                @(posedge clk);
                #1;
            end
            sck = 1'b1;
            wait_cycles(4);
            sck = 1'b0;
        end
        if (end_mode == 0) begin
            wait_cycles(4);
            cs_n = 1'b1;
            wait_cycles(8);
        end else if (end_mode == 1) begin
            sdi = 1'b1;
            wait_cycles(4);
            sck  = 1'b1;
            cs_n = 1'b1;
            wait_cycles(4);
            sck = 1'b0;
            wait_cycles(4);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            wait_cycles(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        cs_n   = 1'b1;
        sck    = 1'b0;
        sdi    = 1'b0;
        uio_in = 8'h00;
        wait_cycles(3);
        @(negedge clk);
        check("reset_uo_out",  {24'd0, uo_out},  32'd0);
        check("reset_uio_out", {24'd0, uio_out}, 32'd0);
        check("reset_uio_oe",  {24'd0, uio_oe},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(3);

        // Valid frame oe=FF out=A5
        exp_q.push_back({8'hFF, 8'hA5, 1'b0, 1'b1, 4'h0});
        send_frame(18'h0FFA5, 16, 0, 16'h0000);
        drain("drain_f1");

        // Short 15-bit frame: error, pads untouched
        exp_q.push_back({8'hFF, 8'hA5, 1'b1, 1'b1, 4'hF});
        send_frame(18'h01234, 15, 0, 16'hFFA5);
        drain("drain_short");

        // Valid frame clears err
        exp_q.push_back({8'h0F, 8'h3C, 1'b0, 1'b0, 4'h0});
        send_frame(18'h00F3C, 16, 0, 16'hFFA5);
        drain("drain_f3");

        // 18-bit frame: count saturates at 17, error
        exp_q.push_back({8'h0F, 8'h3C, 1'b1, 1'b0, 4'h1});
        send_frame(18'h2ABCD, 18, 0, 16'h0F3C);
        drain("drain_long");

        // Extra sck rise coincident with cs_n rise is discarded
        exp_q.push_back({8'h55, 8'hAA, 1'b0, 1'b1, 4'h0});
        send_frame(18'h055AA, 16, 1, 16'h0F3C);
        drain("drain_coinc");

        // Reset mid-frame after 8 bits
        send_frame(18'h000F0, 8, 2, 16'h55AA);
        rst_n = 1'b0;
        wait_cycles(2);
        cs_n = 1'b1;
        sck  = 1'b0;
        sdi  = 1'b0;
        @(negedge clk);
        check("midrst_uo_out",  {24'd0, uo_out},  32'd0);
        check("midrst_uio_out", {24'd0, uio_out}, 32'd0);
        check("midrst_uio_oe",  {24'd0, uio_oe},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(6);
        @(negedge clk);
        check("post_rst_uo_out", {24'd0, uo_out}, 32'd0);
        @(posedge clk);
        #1;

        // Full frame after reset commits
        exp_q.push_back({8'h3C, 8'h5A, 1'b0, 1'b1, 4'h0});
        send_frame(18'h03C5A, 16, 0, 16'h0000);
        drain("drain_f7");

        // ena low: frame ignored entirely
        ena       = 1'b0;
        busy_seen = 1'b0;
        send_frame(18'h0FFFF, 16, 0, 16'h3C5A);
        wait_cycles(4);
        check("ena_busy_seen", {31'd0, busy_seen}, 32'd0);
        check("ena_uio_out",   {24'd0, uio_out},   32'h5A);
        check("ena_uio_oe",    {24'd0, uio_oe},    32'h3C);
        ena = 1'b1;
        wait_cycles(2);

        // Zero frame: old config 3C5A streams out on sdo in readback builds
        exp_q.push_back({8'h00, 8'h00, 1'b0, 1'b0, 4'h0});
        send_frame(18'h00000, 16, 0, 16'h3C5A);
        drain("drain_f9");

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
